// File: rtl/solar_stepper_drv.sv
// Dual-axis STEP/DIR pulse generator fed by the solar tracker's one-hot requests.
// Each axis steps through IDLE/SETUP/PULSE/GAP and saturates at its soft limits.
module solar_stepper_axis #(
    parameter int STEP_DIV = 1000,
    parameter int PULSE_W  = 10,
    parameter int POS_W    = 16,
    parameter int MAX      = 3599,
    parameter int HOME     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic             step_o,
    output logic             dir_o,
    output logic             lim_o,
    output logic [POS_W-1:0] pos_o,
    output logic             busy_d_o
);
    localparam int CNT_W = $clog2(STEP_DIV) + 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STEP_DIV - PULSE_W - 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [POS_W-1:0] MAX_P      = POS_W'(MAX);
    localparam logic [POS_W-1:0] HOME_P     = POS_W'(HOME);
    localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             lim_q, lim_d;
    logic             want_inc, want_dec, blocked;

    assign want_inc = inc_i & ~dec_i;
    assign want_dec = dec_i & ~inc_i;
    assign blocked  = (want_inc & (pos_q == MAX_P)) |
                      (want_dec & (pos_q == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pos_q   <= HOME_P;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            lim_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            lim_q   <= lim_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        step_d  = step_q;
        dir_d   = dir_q;
        lim_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                lim_d = en_i & (want_inc | want_dec) & blocked;
                if (en_i & (want_inc | want_dec) & ~blocked) begin
                    state_d = SETUP;
                    dir_d   = want_inc;
                end
            end
            SETUP: begin
                // Step edge and position update land on the same clock edge.
                state_d = PULSE;
                step_d  = 1'b1;
                cnt_d   = '0;
                pos_d   = dir_q ? pos_q + POS_ONE : pos_q - POS_ONE;
            end
            PULSE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == PULSE_LAST) begin
                    state_d = GAP;
                    step_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign step_o   = step_q;
    assign dir_o    = dir_q;
    assign lim_o    = lim_q;
    assign pos_o    = pos_q;
    assign busy_d_o = (state_d != IDLE);
endmodule

module solar_stepper_drv #(
    parameter int STEP_DIV = 1000,
    parameter int PULSE_W  = 10,
    parameter int POS_W    = 16,
    parameter int AZ_MAX   = 3599,
    parameter int EL_MAX   = 900,
    parameter int AZ_HOME  = 1800,
    parameter int EL_HOME  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mn,
    input  logic             ms,
    input  logic             me,
    input  logic             mw,
    output logic             el_step,
    output logic             el_dir,
    output logic             az_step,
    output logic             az_dir,
    output logic [POS_W-1:0] el_pos,
    output logic [POS_W-1:0] az_pos,
    output logic             el_lim,
    output logic             az_lim,
    output logic             busy
);
    logic el_busy_d, az_busy_d, busy_q;

    solar_stepper_axis #(
        .STEP_DIV(STEP_DIV), .PULSE_W(PULSE_W), .POS_W(POS_W),
        .MAX(EL_MAX), .HOME(EL_HOME)
    ) u_el (
        .clk(clk), .rst(rst), .en_i(en),
        .inc_i(mn), .dec_i(ms),
        .step_o(el_step), .dir_o(el_dir), .lim_o(el_lim),
        .pos_o(el_pos), .busy_d_o(el_busy_d)
    );

    solar_stepper_axis #(
        .STEP_DIV(STEP_DIV), .PULSE_W(PULSE_W), .POS_W(POS_W),
        .MAX(AZ_MAX), .HOME(AZ_HOME)
    ) u_az (
        .clk(clk), .rst(rst), .en_i(en),
        .inc_i(me), .dec_i(mw),
        .step_o(az_step), .dir_o(az_dir), .lim_o(az_lim),
        .pos_o(az_pos), .busy_d_o(az_busy_d)
    );

    always_ff @(posedge clk) begin
        if (rst) busy_q <= 1'b0;
        else     busy_q <= el_busy_d | az_busy_d;
    end

    assign busy = busy_q;
endmodule

// File: tb/tb_solar_stepper_drv.sv
// Bench for solar_stepper_drv: directed scenarios then random requests,
// compared every cycle against a step-schedule reference model.
module tb_solar_stepper_drv;
    localparam int STEP_DIV = 8;
    localparam int PULSE_W  = 2;
    localparam int POS_W    = 16;
    localparam int AZ_MAX   = 1810;
    localparam int EL_MAX   = 4;
    localparam int AZ_HOME  = 1800;
    localparam int EL_HOME  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, mn = 1'b0, ms = 1'b0, me = 1'b0, mw = 1'b0;
    logic el_step, el_dir, az_step, az_dir, el_lim, az_lim, busy;
    logic [POS_W-1:0] el_pos, az_pos;

    solar_stepper_drv #(
        .STEP_DIV(STEP_DIV), .PULSE_W(PULSE_W), .POS_W(POS_W),
        .AZ_MAX(AZ_MAX), .EL_MAX(EL_MAX),
        .AZ_HOME(AZ_HOME), .EL_HOME(EL_HOME)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .mn(mn), .ms(ms), .me(me), .mw(mw),
        .el_step(el_step), .el_dir(el_dir),
        .az_step(az_step), .az_dir(az_dir),
        .el_pos(el_pos), .az_pos(az_pos),
        .el_lim(el_lim), .az_lim(az_lim),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: each axis remembers the edge at which its last step was accepted.
    int k = 0;
    int st[2] = '{-1000, -1000};
    int mpos[2] = '{EL_HOME, AZ_HOME};
    bit mdir[2] = '{1'b0, 1'b0};
    bit mlim[2] = '{1'b0, 1'b0};
    int nchk = 0, npass = 0, nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s edge=%0d observed=%0d expected=%0d",
                   tag, k, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit up[2], dn[2];
        int mx[2], hm[2];
        bit inc, dec, blk;
        up[0] = mn; dn[0] = ms;
        up[1] = me; dn[1] = mw;
        mx = '{EL_MAX, AZ_MAX};
        hm = '{EL_HOME, AZ_HOME};
        k++;
        for (int a = 0; a < 2; a++) begin
            if (rst) begin
                st[a] = -1000; mpos[a] = hm[a];
                mdir[a] = 1'b0; mlim[a] = 1'b0;
            end else begin
                if (k == st[a] + 1) mpos[a] += mdir[a] ? 1 : -1;
                mlim[a] = 1'b0;
                if (k - st[a] > STEP_DIV) begin
                    inc = up[a] && !dn[a];
                    dec = dn[a] && !up[a];
                    blk = (inc && mpos[a] == mx[a]) || (dec && mpos[a] == 0);
                    if (en && (inc || dec)) begin
                        if (blk) mlim[a] = 1'b1;
                        else begin
                            st[a] = k;
                            mdir[a] = inc;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        bit es[2];
        bit eb;
        eb = 1'b0;
        for (int a = 0; a < 2; a++) begin
            es[a] = (k - st[a] >= 1) && (k - st[a] <= PULSE_W);
            if (k - st[a] >= 0 && k - st[a] < STEP_DIV) eb = 1'b1;
        end
        chk("el_step", 32'(el_step), 32'(es[0]));
        chk("az_step", 32'(az_step), 32'(es[1]));
        chk("el_dir", 32'(el_dir), 32'(mdir[0]));
        chk("az_dir", 32'(az_dir), 32'(mdir[1]));
        chk("el_pos", 32'(el_pos), 32'(mpos[0]));
        chk("az_pos", 32'(az_pos), 32'(mpos[1]));
        chk("el_lim", 32'(el_lim), 32'(mlim[0]));
        chk("az_lim", 32'(az_lim), 32'(mlim[1]));
        chk("busy", 32'(busy), 32'(eb));
    endtask

    task automatic cyc(input bit r, input bit e, input bit n, input bit s,
                       input bit ea, input bit w);
        @(negedge clk);
        rst = r; en = e; mn = n; ms = s; me = ea; mw = w;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    initial begin
        // Reset
        repeat (2) cyc(1, 0, 0, 0, 0, 0);
        chk("rst_el_pos", 32'(el_pos), 32'(EL_HOME));
        chk("rst_az_pos", 32'(az_pos), 32'(AZ_HOME));
        chk("rst_busy", 32'(busy), 32'd0);

        // Single elevation step
        cyc(0, 1, 1, 0, 0, 0);
        chk("single_dir", 32'(el_dir), 32'd1);
        chk("single_setup_step", 32'(el_step), 32'd0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("single_rise", 32'(el_step), 32'd1);
        chk("single_pos", 32'(el_pos), 32'd1);
        repeat (10) cyc(0, 1, 0, 0, 0, 0);
        chk("single_idle", 32'(busy), 32'd0);

        // Continuous east request
        repeat (40) cyc(0, 1, 0, 0, 1, 0);
        repeat (10) cyc(0, 1, 0, 0, 0, 0);
        chk("cont_az_pos", 32'(az_pos), 32'(AZ_HOME + 5));
        chk("cont_el_pos", 32'(el_pos), 32'd1);

        // Elevation upper limit, then back off south
        repeat (50) cyc(0, 1, 1, 0, 0, 0);
        chk("lim_el_pos", 32'(el_pos), 32'(EL_MAX));
        chk("lim_el_lim", 32'(el_lim), 32'd1);
        cyc(0, 1, 0, 1, 0, 0);
        chk("lim_release", 32'(el_lim), 32'd0);
        repeat (10) cyc(0, 1, 0, 0, 0, 0);
        chk("lim_down_pos", 32'(el_pos), 32'(EL_MAX - 1));

        // Conflicting, simultaneous and reversed requests
        repeat (12) cyc(0, 1, 1, 1, 0, 0);
        repeat (12) cyc(0, 1, 1, 0, 1, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 1, 0, 0, 0);
        repeat (20) cyc(0, 1, 0, 1, 0, 0);
        repeat (10) cyc(0, 1, 0, 0, 0, 0);

        // Enable low, and enable dropped mid-gap
        repeat (12) cyc(0, 0, 0, 0, 1, 0);
        chk("en_low_az_lim", 32'(az_lim), 32'd0);
        cyc(0, 1, 0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0, 0, 1);
        repeat (10) cyc(0, 0, 0, 0, 0, 0);

        // Reset during a pulse
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("pre_rst_step", 32'(az_step), 32'd1);
        cyc(1, 1, 0, 0, 0, 0);
        chk("rst_pulse_step", 32'(az_step), 32'd0);
        chk("rst_pulse_pos", 32'(az_pos), 32'(AZ_HOME));
        chk("rst_pulse_busy", 32'(busy), 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 799) == 0),
                ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 1) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
